// File: rtl/blit_pkg.sv
// Shared types and defaults for the sprite blitter: FSM state encoding,
// framebuffer geometry and colour key, plus the empty-rectangle test.
package blit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    COPY,
    DRAIN,
    NEXT,
    DONE
  } blit_state_t;

  localparam int         FB_W_DEFAULT   = 160;
  localparam int         FB_H_DEFAULT   = 120;
  localparam logic [7:0] TRANSP_DEFAULT = 8'hE3;

  // Bounds are inclusive, so a rectangle is empty only when an end lies before its start.
  function automatic logic rect_empty(input logic [9:0] x0, input logic [9:0] y0,
                                      input logic [9:0] x1, input logic [9:0] y1);
    return (x1 < x0) || (y1 < y0);
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster-order x/y walker over an inclusive rectangle; flags the final pixel
// so the blitter knows when the last read has been issued.
module rect_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [9:0] start_x,
  input  logic [9:0] start_y,
  input  logic [9:0] min_x,
  input  logic [9:0] max_x,
  input  logic [9:0] max_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       last
);

  // load seeds the origin; each step advances x and wraps to the next row at max_x.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= start_x;
      y <= start_y;
    end else if (step) begin
      if (x == max_x) begin
        x <= min_x;
        y <= y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  assign last = (x == max_x) && (y == max_y);

endmodule

// File: rtl/sprite_blitter.sv
// Composites NUM_LAYERS rectangles from VRAM into the framebuffer, one layer at a
// time, dropping colour-keyed pixels and anything that lands outside the framebuffer.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int               NUM_LAYERS = 14,
  parameter int               PIX_W      = 8,
  parameter logic [PIX_W-1:0] TRANSP     = TRANSP_DEFAULT,
  parameter int               FB_W       = FB_W_DEFAULT,
  parameter int               FB_H       = FB_H_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [31:0]      layer,
  input  logic [9:0]       vram_inicio_X,
  input  logic [9:0]       vram_inicio_Y,
  input  logic [9:0]       vram_final_X,
  input  logic [9:0]       vram_final_Y,
  input  logic [9:0]       FB_X,
  input  logic [9:0]       FB_Y,
  output logic [9:0]       vram_x,
  output logic [9:0]       vram_y,
  output logic             vram_rd,
  input  logic [PIX_W-1:0] vram_data,
  output logic [9:0]       fb_x,
  output logic [9:0]       fb_y,
  output logic [PIX_W-1:0] fb_data,
  output logic             fb_we,
  output logic             busy,
  output logic             done
);

  blit_state_t state;

  logic [9:0]  src_x0, src_y0, src_x1, src_y1;
  logic [9:0]  dst_x0, dst_y0;
  logic        scan_last;
  logic        pending;
  logic        in_bounds;
  logic [10:0] wr_x, wr_y;

  rect_scanner u_scanner (
    .clk     (clk),
    .reset   (reset),
    .load    (state == LATCH),
    .step    ((state == COPY) && !scan_last),
    .start_x (vram_inicio_X),
    .start_y (vram_inicio_Y),
    .min_x   (src_x0),
    .max_x   (src_x1),
    .max_y   (src_y1),
    .x       (vram_x),
    .y       (vram_y),
    .last    (scan_last)
  );

  // Destination is computed one bit wider so clipping sees overflow past 1023.
  always_comb begin
    wr_x = {1'b0, dst_x0} + {1'b0, 10'(vram_x - src_x0)};
    wr_y = {1'b0, dst_y0} + {1'b0, 10'(vram_y - src_y0)};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      layer     <= '0;
      vram_rd   <= 1'b0;
      pending   <= 1'b0;
      in_bounds <= 1'b0;
      fb_x      <= '0;
      fb_y      <= '0;
      src_x0    <= '0;
      src_y0    <= '0;
      src_x1    <= '0;
      src_y1    <= '0;
      dst_x0    <= '0;
      dst_y0    <= '0;
    end else begin
      // Write address trails the read by one cycle to line up with vram_data.
      pending <= vram_rd;
      if (vram_rd) begin
        fb_x      <= wr_x[9:0];
        fb_y      <= wr_y[9:0];
        in_bounds <= (wr_x < 11'(FB_W)) && (wr_y < 11'(FB_H));
      end

      case (state)
        IDLE: begin
          if (start) begin
            layer <= '0;
            state <= LATCH;
          end
        end
        LATCH: begin
          src_x0 <= vram_inicio_X;
          src_y0 <= vram_inicio_Y;
          src_x1 <= vram_final_X;
          src_y1 <= vram_final_Y;
          dst_x0 <= FB_X;
          dst_y0 <= FB_Y;
          if (rect_empty(vram_inicio_X, vram_inicio_Y, vram_final_X, vram_final_Y)) begin
            state <= NEXT;
          end else begin
            vram_rd <= 1'b1;
            state   <= COPY;
          end
        end
        COPY: begin
          if (scan_last) begin
            vram_rd <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          state <= NEXT;
        end
        NEXT: begin
          if (layer == 32'(NUM_LAYERS - 1)) begin
            state <= DONE;
          end else begin
            layer <= layer + 32'd1;
            state <= LATCH;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          vram_rd <= 1'b0;
        end
      endcase
    end
  end

  // Read data arrives combinationally, so the strobe and pixel are gated here.
  assign fb_data = pending ? vram_data : '0;
  assign fb_we   = pending && (vram_data != TRANSP) && in_bounds;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter NUM_LAYERS, default 14, number of layers composited per frame (layers 0..NUM_LAYERS-1).
REQ-002 Parameter PIX_W, default 8, pixel width in bits.
REQ-003 Parameter TRANSP, default 8'hE3, colour key; pixels equal to it are never written.
REQ-004 Parameter FB_W, default 160, and FB_H, default 120, framebuffer dimensions in pixels.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-low reset.
REQ-008 start  in  1  frame-compose request, sampled only in IDLE.
REQ-009 layer  out  32  layer index presented to the scene-description stage.
REQ-010 vram_inicio_X, vram_inicio_Y, vram_final_X, vram_final_Y  in  10 each  inclusive source rectangle for the current layer.
REQ-011 FB_X, FB_Y  in  10 each  destination top-left for the current layer.
REQ-012 vram_x, vram_y  out  10 each  VRAM read coordinate.
REQ-013 vram_rd  out  1  VRAM read strobe.
REQ-014 vram_data  in  PIX_W  read data, valid exactly 1 cycle after vram_rd.
REQ-015 fb_x, fb_y  out  10 each  framebuffer write coordinate.
REQ-016 fb_data  out  PIX_W  write pixel.
REQ-017 fb_we  out  1  framebuffer write strobe.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when the last layer completes.

Function
REQ-020 FSM states: IDLE, LATCH, COPY, DRAIN, NEXT, DONE.
REQ-021 IDLE: on start=1, go to LATCH with layer=0; otherwise remain in IDLE.
REQ-022 LATCH (1 cycle): capture all six rectangle/destination inputs into internal registers.
  - An empty rectangle (final_X<inicio_X or final_Y<inicio_Y) goes directly to NEXT.
  - Otherwise go to COPY with x=inicio_X, y=inicio_Y.
REQ-023 COPY: assert vram_rd with vram_x=x, vram_y=y every cycle, in raster order (x increments; at final_X, x wraps to inicio_X and y increments).
  - After issuing final_X/final_Y, go to DRAIN.
REQ-024 Write pipeline: for each read issued in cycle t, in cycle t+1 drive fb_x=FB_X+(x-inicio_X) and fb_y=FB_Y+(y-inicio_Y), computed 11 bits wide, and fb_data=vram_data.
REQ-025 fb_we conditions: fb_we=1 only if vram_data!=TRANSP, 11-bit fb_x<FB_W and 11-bit fb_y<FB_H; clipped pixels are dropped silently.
REQ-026 DRAIN (1 cycle): perform the final pending write, then go to NEXT.
REQ-027 NEXT: if layer==NUM_LAYERS-1, go to DONE; else increment layer and go to LATCH.
REQ-028 DONE: pulse done=1 for one cycle, go to IDLE, leaving layer at NUM_LAYERS-1.
REQ-029 Layer timing: a non-empty layer of W*H pixels costs W*H+3 cycles (LATCH, reads, DRAIN, NEXT); an empty layer costs 2 cycles.
REQ-030 Input changes after LATCH do not affect the layer in progress.
REQ-031 start asserted while busy=1 is ignored, not queued.
REQ-032 vram_rd and fb_we are 0 in IDLE, LATCH, NEXT and DONE.

Reset
REQ-033 reset=0 forces, on the next edge, state=IDLE and these outputs to 0: layer, vram_x, vram_y, vram_rd, fb_x, fb_y, fb_data, fb_we, busy, done.
REQ-034 Reset mid-frame aborts immediately: no further fb_we, and no done pulse.

Structure
REQ-035 A shared package blit_pkg holds the FSM state enum, FB_W/FB_H defaults and TRANSP default.
REQ-036 The raster x/y counter with wrap and last-pixel flag is a sub-module named rect_scanner.

Verification
REQ-037 NUM_LAYERS=1, rect (0,0)-(1,1), FB (10,20), all data 8'h11:
  - start -> 4 fb_we at (10,20), (11,20), (10,21), (11,21).
  - done exactly 8 cycles after the start edge is sampled.
REQ-038 Same rect, data 8'h11, TRANSP, 8'h22, TRANSP -> exactly 2 fb_we, at (10,20) and (10,21).
REQ-039 Rect 40x34 at FB (150,110) -> only 10x10=100 fb_we; none with fb_x>=160 or fb_y>=120.
REQ-040 NUM_LAYERS=14 with layer 3 returning final_X<inicio_X -> layer 3 produces no vram_rd, spends 2 cycles, and layers 0..13 appear in order.
REQ-041 reset=0 asserted mid-COPY of layer 5 -> next cycle busy=0, fb_we=0, layer=0; no done pulse.
REQ-042 start re-pulsed during COPY -> ignored; exactly one done pulse per frame.
